// File: rtl/ysyx_lsu_pkg.sv
//------------------------------------------------------------------------------
// Module : ysyx_lsu_pkg
// Brief  : Shared load/store type codes and LSU state encoding.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package ysyx_lsu_pkg;

    localparam logic [4:0] ALU_LB   = 5'd1;
    localparam logic [4:0] ALU_LH   = 5'd2;
    localparam logic [4:0] ALU_LW   = 5'd3;
    localparam logic [4:0] ALU_LBU  = 5'd4;
    localparam logic [4:0] ALU_LHU  = 5'd5;

    localparam logic [4:0] WSTRB_SB = 5'd1;
    localparam logic [4:0] WSTRB_SH = 5'd2;
    localparam logic [4:0] WSTRB_SW = 5'd3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } lsu_state_e;

endpackage

`default_nettype wire

// File: rtl/ysyx_lsu_align.sv
//------------------------------------------------------------------------------
// Module : ysyx_lsu_align
// Brief  : Misalignment check, store lane/strobe generation, load extract/extend.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ysyx_lsu_align
    import ysyx_lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            req_store,
    input  logic [4:0]      req_alu,
    input  logic [1:0]      req_addr_lo,
    input  logic [XLEN-1:0] req_wdata,
    output logic            req_misalign,
    output logic [3:0]      st_wstrb,
    output logic [XLEN-1:0] st_wdata,
    input  logic [4:0]      ld_alu,
    input  logic [1:0]      ld_addr_lo,
    input  logic [XLEN-1:0] ld_rdata,
    output logic [XLEN-1:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        req_misalign = 1'b0;
        if (req_store) begin
            if (req_alu == WSTRB_SH) req_misalign = req_addr_lo[0];
            if (req_alu == WSTRB_SW) req_misalign = |req_addr_lo;
        end else begin
            if (req_alu == ALU_LH || req_alu == ALU_LHU) req_misalign = req_addr_lo[0];
            if (req_alu == ALU_LW) req_misalign = |req_addr_lo;
        end
    end

    always_comb begin
        st_wstrb = 4'b1111;
        st_wdata = req_wdata;
        case (req_alu)
            WSTRB_SB: begin
                st_wstrb = 4'b0001 << req_addr_lo;
                st_wdata = {4{req_wdata[7:0]}};
            end
            WSTRB_SH: begin
                st_wstrb = req_addr_lo[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (ld_addr_lo)
            2'd0:    ld_byte = ld_rdata[7:0];
            2'd1:    ld_byte = ld_rdata[15:8];
            2'd2:    ld_byte = ld_rdata[23:16];
            default: ld_byte = ld_rdata[31:24];
        endcase
        ld_half = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];
        case (ld_alu)
            ALU_LB:  ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            ALU_LBU: ld_data = {{(XLEN-8){1'b0}}, ld_byte};
            ALU_LH:  ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
            ALU_LHU: ld_data = {{(XLEN-16){1'b0}}, ld_half};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/ysyx_lsu.sv
//------------------------------------------------------------------------------
// Module : ysyx_lsu
// Brief  : Single-outstanding load/store unit bridging the EXU to a simple bus.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ysyx_lsu
    import ysyx_lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush_pipeline,
    input  logic            in_ren,
    input  logic [XLEN-1:0] in_raddr,
    input  logic [4:0]      in_ralu,
    input  logic            in_wen,
    input  logic [XLEN-1:0] in_waddr,
    input  logic [4:0]      in_walu,
    input  logic [XLEN-1:0] in_wdata,
    output logic [XLEN-1:0] out_rdata,
    output logic            out_rvalid,
    output logic            out_wready,
    output logic            out_misalign,
    output logic            mem_valid,
    input  logic            mem_ready,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_wstrb,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata
);

    lsu_state_e      state_q, state_d;
    logic            we_q, we_d;
    logic [4:0]      alu_q, alu_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [3:0]      wstrb_q, wstrb_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            rvalid_q, rvalid_d;
    logic            wready_q, wready_d;
    logic            misalign_q, misalign_d;

    logic [4:0]      req_alu;
    logic [XLEN-1:0] req_addr;
    logic            req_misalign;
    logic [3:0]      st_wstrb;
    logic [XLEN-1:0] st_wdata;
    logic [XLEN-1:0] ld_data;

    // Stores take priority when both requests are presented together.
    assign req_alu  = in_wen ? in_walu  : in_ralu;
    assign req_addr = in_wen ? in_waddr : in_raddr;

    ysyx_lsu_align #(.XLEN(XLEN)) u_align (
        .req_store    (in_wen),
        .req_alu      (req_alu),
        .req_addr_lo  (req_addr[1:0]),
        .req_wdata    (in_wdata),
        .req_misalign (req_misalign),
        .st_wstrb     (st_wstrb),
        .st_wdata     (st_wdata),
        .ld_alu       (alu_q),
        .ld_addr_lo   (addr_q[1:0]),
        .ld_rdata     (mem_rdata),
        .ld_data      (ld_data)
    );

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        alu_d      = alu_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        rdata_d    = rdata_q;
        rvalid_d   = 1'b0;
        wready_d   = 1'b0;
        misalign_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!flush_pipeline && (in_wen || in_ren)) begin
                    we_d    = in_wen;
                    alu_d   = req_alu;
                    addr_d  = req_addr;
                    wdata_d = st_wdata;
                    wstrb_d = in_wen ? st_wstrb : 4'b0000;
                    if (req_misalign) begin
                        state_d    = S_DONE;
                        misalign_d = 1'b1;
                        wready_d   = in_wen;
                        rvalid_d   = !in_wen;
                        if (!in_wen) rdata_d = '0;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                // Once accepted, a squashed load still owes a response to swallow.
                if (mem_ready)
                    state_d = (flush_pipeline && !we_q) ? S_DRAIN : S_WAIT;
                else if (flush_pipeline && !we_q)
                    state_d = S_IDLE;
            end
            S_WAIT: begin
                if (flush_pipeline && !we_q) begin
                    state_d = mem_rvalid ? S_IDLE : S_DRAIN;
                end else if (mem_rvalid) begin
                    state_d = S_DONE;
                    if (we_q) begin
                        wready_d = 1'b1;
                    end else begin
                        rvalid_d = 1'b1;
                        rdata_d  = ld_data;
                    end
                end
            end
            S_DRAIN: begin
                if (mem_rvalid) state_d = S_IDLE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            we_q       <= 1'b0;
            alu_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            wready_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            alu_q      <= alu_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            wready_q   <= wready_d;
            misalign_q <= misalign_d;
        end
    end

    assign mem_valid    = (state_q == S_REQ);
    assign mem_we       = mem_valid && we_q;
    assign mem_addr     = {addr_q[XLEN-1:2], 2'b00};
    assign mem_wstrb    = mem_valid ? wstrb_q : 4'b0000;
    assign mem_wdata    = wdata_q;
    assign out_rdata    = rdata_q;
    assign out_rvalid   = rvalid_q;
    assign out_wready   = wready_q;
    assign out_misalign = misalign_q;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_lsu.sv
//------------------------------------------------------------------------------
// Module : tb_ysyx_lsu
// Brief  : Directed self-checking bench for ysyx_lsu.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ysyx_lsu;
    import ysyx_lsu_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush_pipeline;
    logic        in_ren;
    logic [31:0] in_raddr;
    logic [4:0]  in_ralu;
    logic        in_wen;
    logic [31:0] in_waddr;
    logic [4:0]  in_walu;
    logic [31:0] in_wdata;
    logic [31:0] out_rdata;
    logic        out_rvalid;
    logic        out_wready;
    logic        out_misalign;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int vectors = 0;
    int errors  = 0;

    ysyx_lsu #(.XLEN(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .flush_pipeline (flush_pipeline),
        .in_ren         (in_ren),
        .in_raddr       (in_raddr),
        .in_ralu        (in_ralu),
        .in_wen         (in_wen),
        .in_waddr       (in_waddr),
        .in_walu        (in_walu),
        .in_wdata       (in_wdata),
        .out_rdata      (out_rdata),
        .out_rvalid     (out_rvalid),
        .out_wready     (out_wready),
        .out_misalign   (out_misalign),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wstrb      (mem_wstrb),
        .mem_wdata      (mem_wdata),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush_pipeline = 1'b0;
        in_ren = 1'b0; in_raddr = '0; in_ralu = '0;
        in_wen = 1'b0; in_waddr = '0; in_walu = '0; in_wdata = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        tick(); tick();
        vectors++;
        if ({mem_valid, mem_we, mem_wstrb, out_rvalid, out_wready, out_misalign} !== 9'd0 || out_rdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: got v=%b we=%b strb=%b rv=%b wr=%b mis=%b rd=%h expected all zero",
                     mem_valid, mem_we, mem_wstrb, out_rvalid, out_wready, out_misalign, out_rdata);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_load_ext();
        logic [31:0] a [7] = '{32'h8000_0003, 32'h8000_0003, 32'h8000_0002, 32'h8000_0000,
                               32'h8000_0000, 32'h8000_0001, 32'h8000_0002};
        logic [4:0]  t [7] = '{ALU_LB, ALU_LBU, ALU_LH, ALU_LHU, ALU_LW, ALU_LB, ALU_LBU};
        logic [31:0] e [7] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80AA, 32'h0000_BBCC,
                               32'h80AA_BBCC, 32'hFFFF_FFBB, 32'h0000_00AA};
        for (int i = 0; i < 7; i++) begin
            in_ren = 1'b1; in_raddr = a[i]; in_ralu = t[i];
            mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = 32'h80AA_BBCC;
            vectors++;
            if (mem_valid !== 1'b0) begin
                errors++; $display("FAIL load%0d_c0_valid: got %b expected 0", i, mem_valid);
            end
            tick();
            vectors++;
            if (mem_valid !== 1'b1 || mem_we !== 1'b0 || mem_addr !== {a[i][31:2], 2'b00}) begin
                errors++;
                $display("FAIL load%0d_c1_req: got v=%b we=%b addr=%h expected v=1 we=0 addr=%h",
                         i, mem_valid, mem_we, mem_addr, {a[i][31:2], 2'b00});
            end
            tick();
            mem_rvalid = 1'b1;
            vectors++;
            if (mem_valid !== 1'b0 || out_rvalid !== 1'b0) begin
                errors++; $display("FAIL load%0d_c2_wait: got v=%b rv=%b expected 0 0", i, mem_valid, out_rvalid);
            end
            tick();
            mem_rvalid = 1'b0; in_ren = 1'b0;
            vectors++;
            if (out_rvalid !== 1'b1 || out_rdata !== e[i] || out_misalign !== 1'b0) begin
                errors++;
                $display("FAIL load%0d_c3_data: got rv=%b rd=%h mis=%b expected rv=1 rd=%h mis=0",
                         i, out_rvalid, out_rdata, out_misalign, e[i]);
            end
            tick();
            vectors++;
            if (out_rvalid !== 1'b0) begin
                errors++; $display("FAIL load%0d_pulse_width: got rv=%b expected 0", i, out_rvalid);
            end
        end
    endtask

    task automatic test_store_lanes();
        logic [31:0] a [4] = '{32'h0000_1002, 32'h0000_2001, 32'h0000_3000, 32'h0000_2003};
        logic [4:0]  t [4] = '{WSTRB_SH, WSTRB_SB, WSTRB_SW, WSTRB_SB};
        logic [31:0] d [4] = '{32'h0000_1234, 32'h0000_00AB, 32'hDEAD_BEEF, 32'h0000_007F};
        logic [3:0]  s [4] = '{4'b1100, 4'b0010, 4'b1111, 4'b1000};
        logic [31:0] w [4] = '{32'h1234_1234, 32'hABAB_ABAB, 32'hDEAD_BEEF, 32'h7F7F_7F7F};
        for (int i = 0; i < 4; i++) begin
            in_wen = 1'b1; in_waddr = a[i]; in_walu = t[i]; in_wdata = d[i];
            mem_ready = 1'b1; mem_rvalid = 1'b0;
            tick();
            vectors++;
            if (mem_valid !== 1'b1 || mem_we !== 1'b1 || mem_addr !== {a[i][31:2], 2'b00} ||
                mem_wstrb !== s[i] || mem_wdata !== w[i]) begin
                errors++;
                $display("FAIL store%0d_req: got v=%b we=%b addr=%h strb=%b wd=%h expected 1 1 %h %b %h",
                         i, mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata, {a[i][31:2], 2'b00}, s[i], w[i]);
            end
            tick();
            mem_rvalid = 1'b1;
            tick();
            mem_rvalid = 1'b0; in_wen = 1'b0;
            vectors++;
            if (out_wready !== 1'b1 || out_rvalid !== 1'b0 || out_misalign !== 1'b0) begin
                errors++;
                $display("FAIL store%0d_done: got wr=%b rv=%b mis=%b expected 1 0 0", i, out_wready, out_rvalid, out_misalign);
            end
            tick();
            vectors++;
            if (out_wready !== 1'b0) begin
                errors++; $display("FAIL store%0d_pulse_width: got wr=%b expected 0", i, out_wready);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic        acc = 1'b0;
        int          st_cyc = -1, ld_cyc = -1, nw = 0, nr = 0;
        logic [31:0] got = '0;
        in_wen = 1'b1; in_waddr = 32'h100; in_walu = WSTRB_SW; in_wdata = 32'h1111_1111;
        in_ren = 1'b1; in_raddr = 32'h200; in_ralu = ALU_LW;
        mem_ready = 1'b1; mem_rdata = 32'h55AA_55AA;
        for (int c = 0; c < 14; c++) begin
            tick();
            mem_rvalid = acc;
            if (out_wready) begin nw++; in_wen = 1'b0; end
            if (out_rvalid) begin nr++; in_ren = 1'b0; got = out_rdata; end
            if (mem_valid && mem_we && st_cyc < 0) st_cyc = c;
            if (mem_valid && !mem_we && ld_cyc < 0) ld_cyc = c;
            acc = mem_valid & mem_ready;
        end
        mem_rvalid = 1'b0; in_wen = 1'b0; in_ren = 1'b0;
        vectors++;
        if (st_cyc != 0 || ld_cyc != 4) begin
            errors++; $display("FAIL b2b_order: got store@%0d load@%0d expected store@0 load@4", st_cyc, ld_cyc);
        end
        vectors++;
        if (nw != 1 || nr != 1 || got !== 32'h55AA_55AA) begin
            errors++; $display("FAIL b2b_counts: got wr=%0d rv=%0d rd=%h expected 1 1 55aa55aa", nw, nr, got);
        end
    endtask

    task automatic test_misalign();
        in_ren = 1'b1; in_raddr = 32'h1001; in_ralu = ALU_LW;
        vectors++;
        if (mem_valid !== 1'b0) begin
            errors++; $display("FAIL mis_lw_c0: got v=%b expected 0", mem_valid);
        end
        tick();
        in_ren = 1'b0;
        vectors++;
        if (mem_valid !== 1'b0 || out_rvalid !== 1'b1 || out_misalign !== 1'b1 || out_rdata !== 32'd0) begin
            errors++;
            $display("FAIL mis_lw_c1: got v=%b rv=%b mis=%b rd=%h expected 0 1 1 00000000",
                     mem_valid, out_rvalid, out_misalign, out_rdata);
        end
        tick();
        vectors++;
        if (out_rvalid !== 1'b0 || out_misalign !== 1'b0 || mem_valid !== 1'b0) begin
            errors++; $display("FAIL mis_lw_c2: got rv=%b mis=%b v=%b expected 0 0 0", out_rvalid, out_misalign, mem_valid);
        end
        in_wen = 1'b1; in_waddr = 32'h1001; in_walu = WSTRB_SH; in_wdata = 32'h5678;
        tick();
        in_wen = 1'b0;
        vectors++;
        if (mem_valid !== 1'b0 || out_wready !== 1'b1 || out_misalign !== 1'b1 || out_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL mis_sh_c1: got v=%b wr=%b mis=%b rv=%b expected 0 1 1 0", mem_valid, out_wready, out_misalign, out_rvalid);
        end
        tick();
    endtask

    task automatic test_flush();
        int bad = 0;
        // Squash while waiting for the response.
        in_ren = 1'b1; in_raddr = 32'h40; in_ralu = ALU_LW; mem_ready = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        tick();
        vectors++;
        if (mem_valid !== 1'b1) begin
            errors++; $display("FAIL flush_wait_req: got v=%b expected 1", mem_valid);
        end
        tick();
        flush_pipeline = 1'b1; in_ren = 1'b0;
        for (int c = 3; c <= 6; c++) begin
            tick();
            flush_pipeline = 1'b0;
            mem_rvalid = (c == 5);
            if (out_rvalid !== 1'b0 || mem_valid !== 1'b0) bad++;
        end
        mem_rvalid = 1'b0;
        vectors++;
        if (bad != 0 || out_rdata !== 32'd0) begin
            errors++; $display("FAIL flush_wait_drain: got %0d bad cycles rd=%h expected 0 bad rd=00000000", bad, out_rdata);
        end
        in_ren = 1'b1; in_raddr = 32'h44; mem_rdata = 32'h1234_5678;
        tick();
        vectors++;
        if (mem_valid !== 1'b1 || mem_addr !== 32'h44) begin
            errors++; $display("FAIL flush_next_req: got v=%b addr=%h expected 1 00000044", mem_valid, mem_addr);
        end
        tick();
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0; in_ren = 1'b0;
        vectors++;
        if (out_rvalid !== 1'b1 || out_rdata !== 32'h1234_5678) begin
            errors++; $display("FAIL flush_next_data: got rv=%b rd=%h expected 1 12345678", out_rvalid, out_rdata);
        end
        tick();
        // Squash before the bus accepts.
        in_ren = 1'b1; in_raddr = 32'h60; mem_ready = 1'b0;
        tick();
        flush_pipeline = 1'b1; in_ren = 1'b0;
        tick();
        flush_pipeline = 1'b0;
        tick();
        vectors++;
        if (mem_valid !== 1'b0 || out_rvalid !== 1'b0) begin
            errors++; $display("FAIL flush_req_drop: got v=%b rv=%b expected 0 0", mem_valid, out_rvalid);
        end
        mem_ready = 1'b1;
        // Stores ignore flush.
        in_wen = 1'b1; in_waddr = 32'h80; in_walu = WSTRB_SW; in_wdata = 32'hCAFE_F00D;
        tick();
        flush_pipeline = 1'b1;
        tick();
        mem_rvalid = 1'b1;
        tick();
        flush_pipeline = 1'b0; mem_rvalid = 1'b0; in_wen = 1'b0;
        vectors++;
        if (out_wready !== 1'b1) begin
            errors++; $display("FAIL flush_store: got wr=%b expected 1", out_wready);
        end
        tick();
    endtask

    task automatic test_stall_reset();
        int unstable = 0;
        in_wen = 1'b1; in_waddr = 32'h500; in_walu = WSTRB_SW; in_wdata = 32'hA5A5_A5A5; mem_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (mem_valid !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h500 ||
                mem_wstrb !== 4'b1111 || mem_wdata !== 32'hA5A5_A5A5) unstable++;
        end
        mem_ready = 1'b1;
        vectors++;
        if (unstable != 0) begin
            errors++; $display("FAIL stall_stable: got %0d unstable cycles expected 0", unstable);
        end
        tick();
        vectors++;
        if (mem_valid !== 1'b0) begin
            errors++; $display("FAIL stall_accept: got v=%b expected 0", mem_valid);
        end
        reset = 1'b1; in_wen = 1'b0;
        tick();
        reset = 1'b0; mem_rvalid = 1'b1;
        vectors++;
        if ({mem_valid, mem_we, mem_wstrb, out_rvalid, out_wready, out_misalign} !== 9'd0 || out_rdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_in_wait: got v=%b we=%b strb=%b rv=%b wr=%b mis=%b rd=%h expected all zero",
                     mem_valid, mem_we, mem_wstrb, out_rvalid, out_wready, out_misalign, out_rdata);
        end
        tick();
        mem_rvalid = 1'b0;
        vectors++;
        if (out_wready !== 1'b0 || out_rvalid !== 1'b0 || mem_valid !== 1'b0) begin
            errors++; $display("FAIL late_rvalid: got wr=%b rv=%b v=%b expected 0 0 0", out_wready, out_rvalid, mem_valid);
        end
    endtask

    initial begin
        test_reset();
        test_load_ext();
        test_store_lanes();
        test_back_to_back();
        test_misalign();
        test_flush();
        test_stall_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ysyx_lsu.md
YSYX_LSU -- requirements
Module: ysyx_lsu

Interface
REQ-001 Parameter XLEN, default 32, data/address width; only 32 supported (4-byte strobe).
REQ-002 clock  in  1  system clock; reset  in  1  synchronous, active-high.
REQ-003 flush_pipeline  in  1  squash in-flight load results.
REQ-004 in_ren  in  1  load request from EXU, level-held until rvalid observed.
REQ-005 in_raddr  in  XLEN  load byte address; in_ralu  in  5  load type (ALU_LB_/LH_/LW_/LBU/LHU).
REQ-006 in_wen  in  1  committed store request, level-held until wready.
REQ-007 in_waddr  in  XLEN  store byte address; in_walu  in  5  store size (WSTRB_SB/SH/SW); in_wdata  in  XLEN  store data, LSB-aligned.
REQ-008 out_rdata  out  XLEN  extended load data; out_rvalid  out  1  one-cycle load-done pulse; out_wready  out  1  one-cycle store-done pulse; out_misalign  out  1  pulses with rvalid/wready on misaligned access.
REQ-009 mem_valid  out  1  bus request; mem_ready  in  1  bus accept; mem_we  out  1; mem_addr  out  XLEN  word-aligned; mem_wstrb  out  4; mem_wdata  out  XLEN  lane-shifted.
REQ-010 mem_rvalid  in  1  response (load data or store ack); mem_rdata  in  XLEN.

Function
REQ-011 FSM states IDLE, REQ, WAIT, DRAIN, DONE; one transaction outstanding maximum.
REQ-012 IDLE: in_wen sampled first; store wins over simultaneous load; latch addr/type/data, go REQ next cycle.
REQ-013 REQ: mem_valid=1 with latched fields held stable until mem_ready; on mem_valid&&mem_ready go WAIT.
REQ-014 WAIT: on mem_rvalid go DONE; load registers extended data into out_rdata and pulses out_rvalid in that same DONE cycle; store pulses out_wready.
REQ-015 Minimum latency: request seen cycle 0, mem_valid cycle 1, with mem_ready=1 and mem_rvalid cycle 2, pulse in cycle 3.
REQ-016 DONE lasts exactly one cycle, ignores in_ren/in_wen, returns IDLE (lets EXU drop its held request).
REQ-017 Load extension: byte/half selected by addr[1:0]/addr[1]; LB/LH sign-extend; LBU/LHU zero-extend; LW pass-through.
REQ-018 Store lanes: SB wstrb=0001<<addr[1:0], data byte replicated; SH wstrb=0011<<(2*addr[1]), half replicated; SW wstrb=1111.
REQ-019 Misaligned (LH/LHU/SH addr[0]=1; LW/SW addr[1:0]!=0): no bus request; IDLE->DONE directly; out_misalign=1 with pulse; load out_rdata=0.
REQ-020 Flush on a load in REQ: drop request if mem_ready not yet seen, return IDLE; in WAIT: go DRAIN, swallow mem_rvalid, return IDLE, no out_rvalid.
REQ-021 Flush on a store: ignored; store completes and out_wready pulses.
REQ-022 Flush in IDLE cycle with request: request not latched.
REQ-023 mem_rvalid outside WAIT/DRAIN ignored; mem_addr[1:0]=0 always.

Reset
REQ-024 Reset: state=IDLE, mem_valid=0, mem_we=0, mem_wstrb=0, out_rvalid=0, out_wready=0, out_misalign=0, out_rdata=0.
REQ-025 Reset mid-transaction abandons it with no pulse; late mem_rvalid after reset ignored.

Structure
REQ-026 ALU_L*/WSTRB_S* codes and the state enum live in the shared ysyx package header; no local encodings.
REQ-027 One sub-module ysyx_lsu_align (combinational load extract/extend and store lane/strobe generation).

Verification
REQ-028 LB addr 0x8000_0003, mem_rdata 0x80AA_BBCC, zero-wait bus -> rvalid cycle 3, out_rdata 0xFFFF_FF80; LBU -> 0x0000_0080.
REQ-029 SH addr 0x1002 data 0x0000_1234 -> mem_addr 0x1000, wstrb 1100, wdata 0x1234_1234; wready one pulse.
REQ-030 in_wen and in_ren same cycle -> store issued first, load issued after DONE, both complete once each.
REQ-031 LW addr 0x1001 -> no mem_valid, rvalid+misalign pulse cycle 1, out_rdata 0.
REQ-032 Load in WAIT + flush, mem_rvalid 3 cycles later -> no out_rvalid, FSM IDLE; next load completes normally.
REQ-033 mem_ready low 5 cycles -> mem_valid/addr/wstrb/wdata stable throughout; reset in WAIT -> no pulse, outputs at reset values.
